// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: two-master round-robin arbiter for a shared 4-bit register bus.
// A granted master's address/data are latched and presented on the bus with
// bus_valid until bus_ack. Read-back is captured while the transaction is
// open, and the owner then gets a one-cycle done (plus rvalid if data was read).
//
// Handshake: a master raises mN_req and holds it (with addr/data) until its
// mN_done pulse. The arbiter holds bus_valid/bus_addr/bus_data stable from the
// cycle after the grant until the cycle in which bus_ack is sampled high. Acks
// and read-back strobes seen while no transaction is open are ignored.
//
// Optional feature: define ARB_TIMEOUT_EN to abort a transaction after TIMEOUT
// cycles without bus_ack. The abort completes the transaction with done, no
// rvalid, and a one-cycle fault pulse. Without the macro, the arbiter waits for
// bus_ack indefinitely and fault is tied low.
module reg_bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    // requester 0
    input  logic       m0_req,
    input  logic [3:0] m0_addr,
    input  logic [3:0] m0_data,
    output logic       m0_done,
    output logic [3:0] m0_rdata,
    output logic       m0_rvalid,
    // requester 1
    input  logic       m1_req,
    input  logic [3:0] m1_addr,
    input  logic [3:0] m1_data,
    output logic       m1_done,
    output logic [3:0] m1_rdata,
    output logic       m1_rvalid,
    // shared register bus
    output logic [3:0] bus_addr,
    output logic [3:0] bus_data,
    output logic       bus_valid,
    input  logic       bus_ack,
    input  logic [3:0] bus_rdata,
    input  logic       bus_rvalid,
    // status
    output logic       busy,
    output logic       fault
);

    // The timeout value must fit the 8-bit cycle counter.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("reg_bus_arbiter: TIMEOUT must be in 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Owner / last-served encoding: 0 = m0, 1 = m1.
    state_e     state_q,    state_d;
    logic [3:0] bus_addr_q, bus_addr_d;
    logic [3:0] bus_data_q, bus_data_d;
    logic       owner_q,    owner_d;
    logic       last_q,     last_d;
    logic       cap_q,      cap_d;
    logic [3:0] m0_rdata_q, m0_rdata_d;
    logic [3:0] m1_rdata_q, m1_rdata_d;

    logic       any_req;
    logic       grant_m1;
    logic       abort_now;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       timed_out_q, timed_out_d;
`endif

    // Round-robin pick: a lone requester always wins; with both requesting,
    // the master not served last wins.
    always_comb begin
        any_req  = m0_req | m1_req;
        grant_m1 = m1_req & (~m0_req | ~last_q);
    end

    // Timeout detection: the counter reaches its last value in a REQ cycle
    // with no ack; an ack arriving in that same cycle still completes normally.
`ifdef ARB_TIMEOUT_EN
    always_comb begin
        abort_now = (state_q == S_REQ) && !bus_ack && (tmo_cnt_q == TIMEOUT_LAST);
    end
`else
    always_comb begin
        abort_now = 1'b0;
    end
`endif

    // Next-state logic for the FSM and all datapath registers.
    always_comb begin
        state_d    = state_q;
        bus_addr_d = bus_addr_q;
        bus_data_d = bus_data_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cap_d      = cap_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
`ifdef ARB_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        timed_out_d = timed_out_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    owner_d    = grant_m1;
                    last_d     = grant_m1;
                    bus_addr_d = grant_m1 ? m1_addr : m0_addr;
                    bus_data_d = grant_m1 ? m1_data : m0_data;
                    cap_d      = 1'b0;
                    state_d    = S_REQ;
`ifdef ARB_TIMEOUT_EN
                    tmo_cnt_d   = 8'd0;
                    timed_out_d = 1'b0;
`endif
                end
            end

            S_REQ: begin
                // Read-back is accepted in every REQ cycle, including the ack
                // cycle; a later strobe overwrites an earlier one.
                if (bus_rvalid) begin
                    cap_d = 1'b1;
                    if (owner_q) begin
                        m1_rdata_d = bus_rdata;
                    end else begin
                        m0_rdata_d = bus_rdata;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + 8'd1;
`endif
                if (bus_ack) begin
                    state_d = S_DONE;
                end else if (abort_now) begin
                    state_d = S_DONE;
`ifdef ARB_TIMEOUT_EN
                    timed_out_d = 1'b1;
`endif
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bus_addr_q <= 4'd0;
            bus_data_q <= 4'd0;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;   // m1 counts as last served, so m0 wins first
            cap_q      <= 1'b0;
            m0_rdata_q <= 4'd0;
            m1_rdata_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            bus_addr_q <= bus_addr_d;
            bus_data_q <= bus_data_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cap_q      <= cap_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Timeout counter and abort flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q   <= 8'd0;
            timed_out_q <= 1'b0;
        end else begin
            tmo_cnt_q   <= tmo_cnt_d;
            timed_out_q <= timed_out_d;
        end
    end
`endif

    // Output decode: bus strobe in REQ, owner-qualified pulses in DONE.
    always_comb begin
        bus_valid = (state_q == S_REQ);
        bus_addr  = bus_addr_q;
        bus_data  = bus_data_q;
        busy      = (state_q != S_IDLE);
        m0_rdata  = m0_rdata_q;
        m1_rdata  = m1_rdata_q;
        m0_done   = (state_q == S_DONE) && !owner_q;
        m1_done   = (state_q == S_DONE) &&  owner_q;
`ifdef ARB_TIMEOUT_EN
        m0_rvalid = m0_done && cap_q && !timed_out_q;
        m1_rvalid = m1_done && cap_q && !timed_out_q;
        fault     = (state_q == S_DONE) && timed_out_q;
`else
        m0_rvalid = m0_done && cap_q;
        m1_rvalid = m1_done && cap_q;
        fault     = 1'b0;
`endif
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Testbench for reg_bus_arbiter. Expected transactions (owner, addr, data,
// read-back) are queued when requests are raised and checked as the bus and
// done pulses appear. Define ARB_TIMEOUT_EN to also exercise the abort path.
module tb_reg_bus_arbiter;

  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       m0_req, m1_req;
  logic [3:0] m0_addr, m0_data, m1_addr, m1_data;
  logic       m0_done, m1_done, m0_rvalid, m1_rvalid;
  logic [3:0] m0_rdata, m1_rdata;
  logic [3:0] bus_addr, bus_data, bus_rdata;
  logic       bus_valid, bus_ack, bus_rvalid;
  logic       busy, fault;

  int n_checks = 0;
  int n_fail   = 0;

  // {owner, addr, data, rvalid expected, rdata expected}
  logic [13:0] exp_q[$];

  reg_bus_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_data(m0_data),
    .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_data(m1_data),
    .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .bus_addr(bus_addr), .bus_data(bus_data), .bus_valid(bus_valid),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
    .busy(busy), .fault(fault)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] pack_exp(input logic m, input logic [3:0] a, input logic [3:0] d,
                                           input logic rv, input logic [3:0] rd);
    return {m, a, d, rv, rd};
  endfunction

  // Act as the bus slave for one transaction: ack in REQ cycle nreq, read-back
  // strobes in cycles rv_a / rv_b (0 = none), then check the DONE and IDLE cycles.
  task automatic serve(input int nreq, input int rv_a, input logic [3:0] rd_a,
                       input int rv_b, input logic [3:0] rd_b, input bit drop);
    logic [13:0] e;
    logic        m, rv;
    logic [3:0]  a, d, rd;
    int          waited;
    waited = 0;
    while (!bus_valid && waited < 20) begin
      tick();
      waited++;
    end
    if (!bus_valid) begin
      check_eq("bus_valid_wait", 32'(bus_valid), 32'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      check_eq("exp_q_empty", 32'd1, 32'd0);
      return;
    end
    e  = exp_q.pop_front();
    m  = e[13];
    a  = e[12:9];
    d  = e[8:5];
    rv = e[4];
    rd = e[3:0];
    for (int i = 1; i <= nreq; i++) begin
      check_eq("req_valid", 32'(bus_valid), 32'd1);
      check_eq("req_addr", 32'(bus_addr), 32'(a));
      check_eq("req_data", 32'(bus_data), 32'(d));
      check_eq("req_no_done", 32'({m0_done, m1_done}), 32'd0);
      bus_ack    = (i == nreq);
      bus_rvalid = (i == rv_a) || (i == rv_b);
      bus_rdata  = (i == rv_b) ? rd_b : rd_a;
      tick();
      bus_ack    = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata  = 4'h0;
    end
    // DONE cycle
    check_eq("done_valid_low", 32'(bus_valid), 32'd0);
    check_eq("done_owner", 32'({m1_done, m0_done}), m ? 32'd2 : 32'd1);
    check_eq("done_rvalid", 32'({m1_rvalid, m0_rvalid}), rv ? (m ? 32'd2 : 32'd1) : 32'd0);
    if (rv) check_eq("done_rdata", 32'(m ? m1_rdata : m0_rdata), 32'(rd));
    check_eq("done_fault", 32'(fault), 32'd0);
    if (drop) begin
      if (m) m1_req = 1'b0;
      else   m0_req = 1'b0;
    end
    tick();
    // IDLE cycle: no pulses, no strobe before re-arbitration
    check_eq("idle_done", 32'({m0_done, m1_done, m0_rvalid, m1_rvalid}), 32'd0);
    check_eq("idle_valid", 32'(bus_valid), 32'd0);
    check_eq("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 0; m1_req = 0;
    m0_addr = 0; m0_data = 0; m1_addr = 0; m1_data = 0;
    bus_ack = 0; bus_rvalid = 0; bus_rdata = 0;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    check_eq("rst_valid", 32'(bus_valid), 32'd0);
    check_eq("rst_addr", 32'(bus_addr), 32'd0);
    check_eq("rst_data", 32'(bus_data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_fault", 32'(fault), 32'd0);
    check_eq("rst_pulses", 32'({m0_done, m1_done, m0_rvalid, m1_rvalid}), 32'd0);
    check_eq("rst_rdata", 32'({m0_rdata, m1_rdata}), 32'd0);

    // m0 write 3/A, ack after 3 REQ cycles; later addr/data changes ignored
    m0_addr = 4'h3; m0_data = 4'hA; m0_req = 1'b1;
    exp_q.push_back(pack_exp(1'b0, 4'h3, 4'hA, 1'b0, 4'h0));
    tick();
    check_eq("latency_valid", 32'(bus_valid), 32'd1);
    check_eq("latency_busy", 32'(busy), 32'd1);
    m0_addr = 4'hF; m0_data = 4'h0;
    serve(3, 0, 4'h0, 0, 4'h0, 1'b1);

    // m1 read addr 5, read-back 7 together with ack
    m1_addr = 4'h5; m1_data = 4'h0; m1_req = 1'b1;
    exp_q.push_back(pack_exp(1'b1, 4'h5, 4'h0, 1'b1, 4'h7));
    serve(2, 0, 4'h0, 2, 4'h7, 1'b1);
    check_eq("m0_rdata_untouched", 32'(m0_rdata), 32'd0);

    // stray ack/read-back in IDLE
    for (int i = 0; i < 3; i++) begin
      bus_ack = 1'b1; bus_rvalid = 1'b1; bus_rdata = 4'hF;
      tick();
      check_eq("stray_busy", 32'(busy), 32'd0);
      check_eq("stray_pulses", 32'({m0_done, m1_done, m0_rvalid, m1_rvalid, bus_valid}), 32'd0);
      check_eq("stray_rdata", 32'({m0_rdata, m1_rdata}), 32'h07);
    end
    bus_ack = 1'b0; bus_rvalid = 1'b0; bus_rdata = 4'h0;
    tick();

    // m0 read with two read-back strobes before ack: the later one wins
    m0_addr = 4'h6; m0_data = 4'h1; m0_req = 1'b1;
    exp_q.push_back(pack_exp(1'b0, 4'h6, 4'h1, 1'b1, 4'h9));
    serve(4, 1, 4'h2, 2, 4'h9, 1'b1);
    check_eq("m1_rdata_held", 32'(m1_rdata), 32'h7);

    // owner drops req mid-transaction; transaction still completes
    m1_addr = 4'h4; m1_data = 4'h3; m1_req = 1'b1;
    exp_q.push_back(pack_exp(1'b1, 4'h4, 4'h3, 1'b0, 4'h0));
    tick();
    check_eq("drop_valid", 32'(bus_valid), 32'd1);
    m1_req = 1'b0;
    serve(2, 0, 4'h0, 0, 4'h0, 1'b1);

    // random single-master transactions
    for (int t = 0; t < 8; t++) begin
      logic       m, rdb;
      logic [3:0] a, d, rv;
      int         n;
      m   = 1'($urandom_range(0, 1));
      a   = 4'($urandom_range(0, 15));
      d   = 4'($urandom_range(0, 15));
      rv  = 4'($urandom_range(0, 15));
      rdb = 1'($urandom_range(0, 1));
      n   = $urandom_range(1, 4);
      if (m) begin m1_addr = a; m1_data = d; m1_req = 1'b1; end
      else   begin m0_addr = a; m0_data = d; m0_req = 1'b1; end
      exp_q.push_back(pack_exp(m, a, d, rdb, rv));
      serve(n, 0, 4'h0, rdb ? n : 0, rv, 1'b1);
    end

    // reset in the 2nd REQ cycle aborts without done
    m0_addr = 4'h8; m0_data = 4'h8; m0_req = 1'b1;
    tick();
    check_eq("abort_valid1", 32'(bus_valid), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort_valid", 32'(bus_valid), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'({m0_done, m1_done}), 32'd0);
    check_eq("abort_rdata", 32'({m0_rdata, m1_rdata}), 32'd0);

    // both requesting continuously: m0 first after reset, then alternate
    m0_addr = 4'h1; m0_data = 4'h2; m0_req = 1'b1;
    m1_addr = 4'hE; m1_data = 4'hD; m1_req = 1'b1;
    exp_q.push_back(pack_exp(1'b0, 4'h1, 4'h2, 1'b0, 4'h0));
    exp_q.push_back(pack_exp(1'b1, 4'hE, 4'hD, 1'b0, 4'h0));
    exp_q.push_back(pack_exp(1'b0, 4'h1, 4'h2, 1'b0, 4'h0));
    exp_q.push_back(pack_exp(1'b1, 4'hE, 4'hD, 1'b0, 4'h0));
    serve(1, 0, 4'h0, 0, 4'h0, 1'b0);
    serve(2, 0, 4'h0, 0, 4'h0, 1'b0);
    serve(1, 0, 4'h0, 0, 4'h0, 1'b1);
    serve(3, 0, 4'h0, 0, 4'h0, 1'b1);
    check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);

`ifdef ARB_TIMEOUT_EN
    // no ack: abort after TMO REQ cycles with done and fault together
    begin
      int cnt;
      m0_addr = 4'h2; m0_data = 4'h2; m0_req = 1'b1;
      tick();
      cnt = 0;
      while (bus_valid && cnt < 300) begin
        bus_rvalid = (cnt == 0);
        bus_rdata  = 4'hC;
        cnt++;
        tick();
        bus_rvalid = 1'b0;
      end
      check_eq("tmo_cycles", 32'(cnt), 32'(TMO));
      check_eq("tmo_done", 32'({m1_done, m0_done}), 32'd1);
      check_eq("tmo_fault", 32'(fault), 32'd1);
      check_eq("tmo_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
      m0_req = 1'b0;
      tick();
      check_eq("tmo_fault_clear", 32'(fault), 32'd0);
      check_eq("tmo_idle", 32'(busy), 32'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
